// File: rtl/axis_frame_driver.sv
// Sends one TX_DATA_NUM-word frame from a host-loaded buffer, then stores one RX_DATA_NUM-word result frame.
// start->m_valid 1 cycle, last s handshake->done 1 cycle; m_ready/s_valid stalls hold state and counters.
module axis_frame_driver #(
  parameter int DATA_WIDTH  = 32,
  parameter int TX_DATA_NUM = 8,
  parameter int RX_DATA_NUM = 4,
  localparam int TXA = (TX_DATA_NUM > 1) ? $clog2(TX_DATA_NUM) : 1,
  localparam int RXA = (RX_DATA_NUM > 1) ? $clog2(RX_DATA_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  last_err,
  input  logic                  txbuf_wr,
  input  logic [TXA-1:0]        txbuf_adr,
  input  logic [DATA_WIDTH-1:0] txbuf_data,
  input  logic [RXA-1:0]        rxbuf_adr,
  output logic [DATA_WIDTH-1:0] rxbuf_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t          state_q, state_d;
  logic [TXA-1:0]  txcnt_q, txcnt_d;
  logic [RXA-1:0]  rxcnt_q, rxcnt_d;
  logic            last_err_q, last_err_d;
  logic            tx_we, rx_we;
  logic            tx_last, rx_last;
  logic            txadr_ok, rxadr_ok;

  logic [DATA_WIDTH-1:0] tx_mem [TX_DATA_NUM];
  logic [DATA_WIDTH-1:0] rx_mem [RX_DATA_NUM];

  assign tx_last  = (txcnt_q == TXA'(TX_DATA_NUM - 1));
  assign rx_last  = (rxcnt_q == RXA'(RX_DATA_NUM - 1));
  // Widened compare so a power-of-two depth does not truncate to zero.
  assign txadr_ok = ({1'b0, txbuf_adr} < (TXA + 1)'(TX_DATA_NUM));
  assign rxadr_ok = ({1'b0, rxbuf_adr} < (RXA + 1)'(RX_DATA_NUM));
  assign last_err = last_err_q;

  always_comb begin
    state_d    = state_q;
    txcnt_d    = txcnt_q;
    rxcnt_d    = rxcnt_q;
    last_err_d = last_err_q;
    busy       = 1'b1;
    done       = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    s_ready    = 1'b0;
    tx_we      = 1'b0;
    rx_we      = 1'b0;
    m_data     = tx_mem[txcnt_q];
    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        txcnt_d = '0;
        rxcnt_d = '0;
        tx_we   = txbuf_wr & txadr_ok;
        if (start) begin
          state_d    = SEND;
          last_err_d = 1'b0;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        m_last  = tx_last;
        if (m_ready) begin
          if (tx_last) begin
            txcnt_d = '0;
            state_d = RECV;
          end else begin
            txcnt_d = txcnt_q + TXA'(1);
          end
        end
      end
      RECV: begin
        s_ready = 1'b1;
        if (s_valid) begin
          rx_we = 1'b1;
          if (s_last != rx_last) last_err_d = 1'b1;
          if (rx_last) begin
            rxcnt_d = '0;
            state_d = DONE;
          end else begin
            rxcnt_d = rxcnt_q + RXA'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      txcnt_q    <= '0;
      rxcnt_q    <= '0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txcnt_q    <= txcnt_d;
      rxcnt_q    <= rxcnt_d;
      last_err_q <= last_err_d;
    end
  end

  // Buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[txbuf_adr] <= txbuf_data;
    if (rx_we) rx_mem[rxcnt_q]   <= s_data;
  end

  assign rxbuf_data = rxadr_ok ? rx_mem[rxbuf_adr] : '0;

endmodule

// File: tb/tb_axis_frame_driver.sv
module tb_axis_frame_driver;
  localparam int DW  = 32;
  localparam int TXN = 8;
  localparam int RXN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, last_err;
  logic          txbuf_wr;
  logic [2:0]    txbuf_adr;
  logic [DW-1:0] txbuf_data;
  logic [1:0]    rxbuf_adr;
  logic [DW-1:0] rxbuf_data;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_ready;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, s_ready;

  axis_frame_driver #(.DATA_WIDTH(DW), .TX_DATA_NUM(TXN), .RX_DATA_NUM(RXN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .last_err(last_err), .txbuf_wr(txbuf_wr), .txbuf_adr(txbuf_adr),
    .txbuf_data(txbuf_data), .rxbuf_adr(rxbuf_adr), .rxbuf_data(rxbuf_data),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] tx_model [TXN];
  logic [DW-1:0] rx_model [RXN];
  logic          exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input bit rnd);
    for (int i = 0; i < TXN; i++) begin
      txbuf_wr   = 1'b1;
      txbuf_adr  = 3'(i);
      txbuf_data = rnd ? $urandom : DW'(i + 1);
      tx_model[i] = txbuf_data;
      step();
    end
    txbuf_wr = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: ready 1,0,0,1 then 1, 2: random ready, 3: random ready + illegal wr/start
  task automatic do_send(input int mode);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < TXN && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      if (mode == 3) begin
        txbuf_wr   = 1'b1;
        txbuf_adr  = 3'($urandom_range(0, TXN - 1));
        txbuf_data = $urandom;
        start      = 1'b1;
      end
      #1;
      chk("send_valid", m_valid, 1);
      chk("send_data", m_data, tx_model[idx]);
      chk("send_last", m_last, idx == TXN - 1);
      chk("send_sready", s_ready, 0);
      if (cyc == 0) chk("send_err_clr", last_err, 0);
      if (rdy) idx++;
      step();
      cyc++;
    end
    chk("send_words", idx, TXN);
    m_ready  = 1'b0;
    txbuf_wr = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_recv(input int last_pos, input bit gaps);
    int k = 0;
    int cyc = 0;
    bit v;
    exp_err = 1'b0;
    while (k < RXN && cyc < 200) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data  = $urandom;
      s_last  = v ? (k == last_pos) : 1'($urandom_range(0, 1));
      #1;
      chk("recv_sready", s_ready, 1);
      chk("recv_mvalid", m_valid, 0);
      chk("recv_done", done, 0);
      chk("recv_err", last_err, exp_err);
      if (v) begin
        rx_model[k] = s_data;
        if (s_last != (k == RXN - 1)) exp_err = 1'b1;
        k++;
      end
      step();
      cyc++;
    end
    chk("recv_words", k, RXN);
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b1;
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_err", last_err, exp_err);
    chk("done_sready", s_ready, 0);
    step();
    start = 1'b0;
    #1;
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("err_sticky", last_err, exp_err);
    step();
    chk("no_restart", busy, 0);
    for (int a = 0; a < RXN; a++) begin
      rxbuf_adr = 2'(a);
      #1;
      chk("rxbuf", rxbuf_data, rx_model[a]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; txbuf_wr = 1'b0; txbuf_adr = '0; txbuf_data = '0;
    rxbuf_adr = '0; m_ready = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    exp_err = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", last_err, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_sready", s_ready, 0);
    rst_n = 1'b1;
    step();

    // Words 1..8, full-rate downstream, clean result frame.
    load_tx(1'b0);
    kick();
    do_send(0);
    do_recv(RXN - 1, 1'b0);
    chk("clean_err", last_err, 0);

    // Stalled downstream, then early s_last.
    load_tx(1'b1);
    kick();
    do_send(1);
    do_recv(1, 1'b1);
    chk("early_last_err", last_err, 1);

    // Writes and start during SEND must not disturb the buffer or restart.
    load_tx(1'b1);
    kick();
    do_send(3);
    do_recv(RXN - 1, 1'b1);
    chk("err_cleared", last_err, 0);
    kick();
    do_send(2);
    do_recv(RXN - 1, 1'b0);

    // Abort during RECV after two words.
    load_tx(1'b1);
    kick();
    do_send(0);
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_data  = $urandom;
      rx_model[k] = s_data;
      step();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sready", s_ready, 0);
    chk("abort_done", done, 0);
    chk("abort_mvalid", m_valid, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_nodone", done, 0);
      chk("abort_idle", busy, 0);
    end
    for (int a = 0; a < 2; a++) begin
      rxbuf_adr = 2'(a);
      #1;
      chk("rxbuf_kept", rxbuf_data, rx_model[a]);
    end
    kick();
    do_send(2);
    do_recv(RXN - 1, 1'b1);
    chk("post_abort_err", last_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
